mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between two requesters: instruction fetch (read-only) and the memory stage (load/store).
- Sits between the fetch unit and memory unit on one side and the unified memory on the other.
- Supports one outstanding access at a time. Data-side requests have priority, bounded by a starvation guard that protects fetch.
- Pipeline stall logic consumes the busy and grant outputs.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    localparam int LAT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single-port fixed-latency memory
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_gnt,
    output logic              o_dm_rvalid,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0] STARVE_LIM = LAT_W'(STARVE_MAX);
    localparam logic [LAT_W-1:0] CNT_ONE    = LAT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    owner_t           r_owner;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [LAT_W-1:0] r_starve_cnt;

    logic w_resp;
    logic w_can_issue;
    logic w_if_win;
    logic w_dm_win;
    logic w_issue;

    // Arbitration: data side wins unless fetch has waited STARVE_MAX data grants
    always_comb begin
        w_resp      = (r_state == ST_BUSY) && (r_lat_cnt == CNT_ONE);
        w_can_issue = i_rst_n && ((r_state == ST_IDLE) || w_resp);
        w_dm_win    = w_can_issue && i_dm_req && (!i_if_req || (r_starve_cnt != STARVE_LIM));
        w_if_win    = w_can_issue && i_if_req && !w_dm_win;
        w_issue     = w_if_win || w_dm_win;
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: an issue always lands in BUSY; the response cycle without a new issue falls back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (w_issue) begin
            w_state_nxt = ST_BUSY;
        end else if (w_resp) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Outputs: grants, memory strobe/mux and owner-steered response pulses
    always_comb begin
        o_if_gnt    = w_if_win;
        o_dm_gnt    = w_dm_win;
        o_mem_en    = w_issue;
        o_mem_we    = w_dm_win && i_dm_we;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_dm_win) begin
            o_mem_addr  = i_dm_addr;
            o_mem_wdata = i_dm_wdata;
        end else if (w_if_win) begin
            o_mem_addr  = i_if_addr;
        end
        o_if_rvalid = w_resp && (r_owner == OWN_IF);
        o_dm_rvalid = w_resp && (r_owner == OWN_DM);
        o_if_rdata  = i_rst_n ? i_mem_rdata : '0;
        o_dm_rdata  = i_rst_n ? i_mem_rdata : '0;
        o_busy      = (r_state == ST_BUSY);
    end

    // Owner and latency countdown for the access in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner   <= OWN_IF;
            r_lat_cnt <= '0;
        end else if (w_issue) begin
            r_owner   <= w_dm_win ? OWN_DM : OWN_IF;
            r_lat_cnt <= LAT_INIT;
        end else if (r_state == ST_BUSY) begin
            r_lat_cnt <= r_lat_cnt - CNT_ONE;
        end
    end

    // Starvation guard: counts data grants taken while fetch is waiting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (!i_if_req || w_if_win) begin
            r_starve_cnt <= '0;
        end else if (w_dm_win && (r_starve_cnt != '1)) begin
            r_starve_cnt <= r_starve_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    // instance A: MEM_LAT = 2
    logic        a_if_req, a_if_gnt, a_if_rvalid;
    logic [31:0] a_if_addr, a_if_rdata;
    logic        a_dm_req, a_dm_we, a_dm_gnt, a_dm_rvalid;
    logic [31:0] a_dm_addr, a_dm_wdata, a_dm_rdata;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata, a_pipe1, a_pipe2;

    // instance B: MEM_LAT = 1
    logic        b_if_req, b_if_gnt, b_if_rvalid;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
    logic [31:0] b_dm_addr, b_dm_wdata, b_dm_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata, b_pipe1;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
    endfunction

    always @(posedge clk) begin
        a_pipe1 <= mem_f(a_mem_addr);
        a_pipe2 <= a_pipe1;
        b_pipe1 <= mem_f(b_mem_addr);
    end
    assign a_mem_rdata = a_pipe2;
    assign b_mem_rdata = b_pipe1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(a_if_req), .i_if_addr(a_if_addr), .o_if_gnt(a_if_gnt),
        .o_if_rvalid(a_if_rvalid), .o_if_rdata(a_if_rdata),
        .i_dm_req(a_dm_req), .i_dm_we(a_dm_we), .i_dm_addr(a_dm_addr), .i_dm_wdata(a_dm_wdata),
        .o_dm_gnt(a_dm_gnt), .o_dm_rvalid(a_dm_rvalid), .o_dm_rdata(a_dm_rdata),
        .o_mem_en(a_mem_en), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr),
        .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata), .o_busy(a_busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(b_if_req), .i_if_addr(b_if_addr), .o_if_gnt(b_if_gnt),
        .o_if_rvalid(b_if_rvalid), .o_if_rdata(b_if_rdata),
        .i_dm_req(b_dm_req), .i_dm_we(b_dm_we), .i_dm_addr(b_dm_addr), .i_dm_wdata(b_dm_wdata),
        .o_dm_gnt(b_dm_gnt), .o_dm_rvalid(b_dm_rvalid), .o_dm_rdata(b_dm_rdata),
        .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata), .o_busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_if_req = 1'b1; a_if_addr = 32'h40; a_dm_req = 1'b1; a_dm_we = 1'b0;
        a_dm_addr = 32'h0; a_dm_wdata = 32'h0;
        b_if_req = 1'b0; b_if_addr = 32'h0; b_dm_req = 1'b0; b_dm_we = 1'b0;
        b_dm_addr = 32'h0; b_dm_wdata = 32'h0;

        // reset state: grants forced low even with requests present
        #2;
        chk("rst_if_gnt", a_if_gnt, 0);
        chk("rst_dm_gnt", a_dm_gnt, 0);
        chk("rst_mem_en", a_mem_en, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_mem_addr", a_mem_addr, 0);
        a_dm_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // fetch-only read of 0x40
        #1;
        chk("f_if_gnt", a_if_gnt, 1);
        chk("f_mem_en", a_mem_en, 1);
        chk("f_mem_addr", a_mem_addr, 32'h40);
        chk("f_mem_we", a_mem_we, 0);
        tick(); a_if_req = 1'b0; #1;
        chk("f_busy_c1", a_busy, 1);
        chk("f_rvalid_c1", a_if_rvalid, 0);
        tick(); #1;
        chk("f_if_rvalid_c2", a_if_rvalid, 1);
        chk("f_if_rdata_c2", a_if_rdata, 32'hDEADBEEF);
        chk("f_dm_rvalid_c2", a_dm_rvalid, 0);
        tick(); #1;
        chk("f_busy_c3", a_busy, 0);
        chk("f_if_rvalid_c3", a_if_rvalid, 0);

        // simultaneous fetch and load: data first, fetch back-to-back
        a_if_req = 1'b1; a_if_addr = 32'h80;
        a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h100;
        #1;
        chk("b2b_dm_gnt_c0", a_dm_gnt, 1);
        chk("b2b_if_gnt_c0", a_if_gnt, 0);
        chk("b2b_addr_c0", a_mem_addr, 32'h100);
        tick(); a_dm_req = 1'b0; #1;
        chk("b2b_if_gnt_c1", a_if_gnt, 0);
        tick(); #1;
        chk("b2b_dm_rvalid_c2", a_dm_rvalid, 1);
        chk("b2b_dm_rdata_c2", a_dm_rdata, mem_f(32'h100));
        chk("b2b_if_gnt_c2", a_if_gnt, 1);
        chk("b2b_addr_c2", a_mem_addr, 32'h80);
        tick(); a_if_req = 1'b0; #1;
        chk("b2b_rvalid_c3", {a_if_rvalid, a_dm_rvalid}, 0);
        tick(); #1;
        chk("b2b_if_rvalid_c4", a_if_rvalid, 1);
        chk("b2b_if_rdata_c4", a_if_rdata, mem_f(32'h80));
        chk("b2b_dm_rvalid_c4", a_dm_rvalid, 0);
        tick(); #1;
        chk("b2b_idle_c5", a_busy, 0);

        // starvation guard: four data grants, then fetch is forced
        a_if_req = 1'b1; a_if_addr = 32'h44;
        a_dm_req = 1'b1; a_dm_addr = 32'h300;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stv_dm_gnt_%0d", k), a_dm_gnt, (k < 4) ? 1 : 0);
            chk($sformatf("stv_if_gnt_%0d", k), a_if_gnt, (k < 4) ? 0 : 1);
            if (k == 4) chk("stv_cnt_at_max", u_a.r_starve_cnt, 4);
            tick();
            if (k == 4) a_if_req = 1'b0;
            #1;
            chk($sformatf("stv_gap_%0d", k), {a_if_gnt, a_dm_gnt}, 0);
            tick();
        end
        chk("stv_cnt_cleared", u_a.r_starve_cnt, 0);
        #1;
        chk("stv_dm_after", a_dm_gnt, 1);
        tick(); a_dm_req = 1'b0; tick(); tick(); #1;
        chk("stv_idle", a_busy, 0);

        // store
        a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 32'h200; a_dm_wdata = 32'h1234;
        #1;
        chk("st_gnt", a_dm_gnt, 1);
        chk("st_mem_we", a_mem_we, 1);
        chk("st_mem_addr", a_mem_addr, 32'h200);
        chk("st_mem_wdata", a_mem_wdata, 32'h1234);
        tick(); a_dm_req = 1'b0; #1;
        chk("st_wdata_idle", a_mem_wdata, 0);
        chk("st_rvalid_c1", a_dm_rvalid, 0);
        tick(); #1;
        chk("st_rvalid_c2", a_dm_rvalid, 1);
        chk("st_if_rvalid_c2", a_if_rvalid, 0);
        tick(); a_dm_we = 1'b0;

        // reset mid-access
        a_if_req = 1'b1; a_if_addr = 32'h48;
        #1;
        chk("rm_gnt", a_if_gnt, 1);
        tick(); a_if_req = 1'b0;
        rst_n = 1'b0; #1;
        chk("rm_busy", a_busy, 0);
        chk("rm_outs", {a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid, a_mem_en, a_mem_we}, 0);
        chk("rm_if_rdata", a_if_rdata, 0);
        chk("rm_mem_addr", a_mem_addr, 0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("rm_no_rvalid_%0d", k), {a_if_rvalid, a_busy}, 0);
            tick();
        end
        a_if_req = 1'b1; a_if_addr = 32'h4C;
        #1;
        chk("rm_regrant", a_if_gnt, 1);
        tick(); a_if_req = 1'b0;

        // MEM_LAT = 1: alternating single requests, one issue per cycle
        for (int k = 0; k < 6; k++) begin
            b_if_req = (k % 2 == 0); b_if_addr = 32'h10 + k;
            b_dm_req = (k % 2 == 1); b_dm_we = 1'b0; b_dm_addr = 32'h20 + k;
            #1;
            chk($sformatf("l1_gnt_%0d", k), {b_if_gnt, b_dm_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("l1_busy_%0d", k), b_busy, (k == 0) ? 0 : 1);
            if (k > 0) begin
                chk($sformatf("l1_rv_%0d", k), {b_if_rvalid, b_dm_rvalid}, (k % 2 == 1) ? 2'b10 : 2'b01);
                chk($sformatf("l1_rdata_%0d", k), b_if_rdata,
                    mem_f((k % 2 == 1) ? 32'h10 + k - 1 : 32'h20 + k - 1));
            end
            tick();
        end
        b_if_req = 1'b0; b_dm_req = 1'b0;
        #1;
        chk("l1_last_rv", {b_if_rvalid, b_dm_rvalid}, 2'b01);
        chk("l1_last_rdata", b_dm_rdata, mem_f(32'h25));
        tick(); #1;
        chk("l1_idle", {b_busy, b_if_rvalid, b_dm_rvalid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
